// File: rtl/hyperram_burst_ctrl.sv
// hyperram_burst_ctrl: one HyperRAM burst per accepted request (CA, latency, data, CS# recovery).
// Latency: request-to-end = 1 + 6 + L (or 2L) + BURST_BYTES + D cycles; reads add the rwds wait.
// Backpressure: ready only in IDLE; requests while busy are ignored, never queued.
module hyperram_burst_ctrl #(
  parameter int BURST_BYTES  = 4,
  parameter int ADDR_WIDTH   = 23,
  parameter int READ_TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDR_WIDTH-1:0]    address,
  input  logic [8*BURST_BYTES-1:0] data_out,
  output logic [8*BURST_BYTES-1:0] data_in,
  input  logic                     write_enable,
  input  logic [BURST_BYTES-1:0]   write_mask,
  input  logic                     reg_space,
  input  logic                     transaction_begin,
  output logic                     ready,
  output logic                     transaction_end,
  output logic                     error,
  input  logic [5:0]               wait_latency,
  input  logic [5:0]               done_latency,
  input  logic                     fixed_latency,
  input  logic                     timed_read,
  output logic [7:0]               dq_out,
  output logic                     dq_oe,
  input  logic [7:0]               dq_in,
  output logic                     rwds_out,
  output logic                     rwds_oe,
  input  logic                     rwds_in,
  output logic                     ck,
  output logic                     ck_bar,
  output logic                     cs_bar
);

  localparam int              DW       = 8 * BURST_BYTES;
  localparam int              TW       = $clog2(READ_TIMEOUT + 1);
  localparam logic [3:0]      LAST_IDX = 4'(BURST_BYTES - 1);
  localparam logic [TW-1:0]   TMO_LAST = TW'(READ_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CA, S_LAT, S_WR, S_RD0, S_RD, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        idx_q, idx_d;      // CA byte / data byte index within the current state
  logic [6:0]        cnt_q, cnt_d;      // shared LAT / DONE cycle counter
  logic [TW-1:0]     tmo_q, tmo_d;      // RD0 wait counter
  logic              lat2_q, lat2_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              ck_q, ck_d;

  // Captured request
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DW-1:0]          wdata_q;
  logic [BURST_BYTES-1:0] mask_q;
  logic                   we_q, reg_q, fixed_q, timed_q;
  logic [5:0]             wlat_q, dlat_q;

  logic        accept;
  logic        reg_wr;
  logic [47:0] ca_word;
  logic [7:0]  ca_byte;
  logic [7:0]  wr_byte;
  logic        wr_mask;
  logic [6:0]  lat_len, lat_tgt, done_len;

  assign accept   = (state_q == S_IDLE) && transaction_begin;
  assign reg_wr   = reg_q & we_q;
  // A programmed count of zero still means one cycle.
  assign lat_len  = (wlat_q == 6'd0) ? 7'd1 : {1'b0, wlat_q};
  assign lat_tgt  = lat2_q ? (lat_len << 1) : lat_len;
  assign done_len = (dlat_q == 6'd0) ? 7'd1 : {1'b0, dlat_q};

  assign ready           = (state_q == S_IDLE) && rst_n;
  assign data_in         = rdata_q;
  assign error           = err_q;
  assign ck              = ck_q;
  assign ck_bar          = ~ck_q;

  // Latch the whole request on accept so the bus may change during the burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      we_q    <= 1'b0;
      reg_q   <= 1'b0;
      fixed_q <= 1'b0;
      timed_q <= 1'b0;
      wlat_q  <= '0;
      dlat_q  <= '0;
    end else if (accept) begin
      addr_q  <= address;
      wdata_q <= data_out;
      mask_q  <= write_mask;
      we_q    <= write_enable;
      reg_q   <= reg_space;
      fixed_q <= fixed_latency;
      timed_q <= timed_read;
      wlat_q  <= wait_latency;
      dlat_q  <= done_latency;
    end
  end

  // Build the 48-bit command/address word and pick the byte for the current CA cycle.
  always_comb begin
    ca_word                        = '0;
    ca_word[47]                    = ~we_q;
    ca_word[46]                    = reg_q;
    ca_word[45]                    = 1'b1;
    ca_word[16 +: ADDR_WIDTH-3]    = addr_q[ADDR_WIDTH-1:3];
    ca_word[2:0]                   = addr_q[2:0];
    case (idx_q)
      4'd0:    ca_byte = ca_word[47:40];
      4'd1:    ca_byte = ca_word[39:32];
      4'd2:    ca_byte = ca_word[31:24];
      4'd3:    ca_byte = ca_word[23:16];
      4'd4:    ca_byte = ca_word[15:8];
      4'd5:    ca_byte = ca_word[7:0];
      default: ca_byte = 8'h00;
    endcase
  end

  // Select the write byte and its mask bit for the current data cycle.
  always_comb begin
    wr_byte = 8'h00;
    wr_mask = 1'b0;
    for (int b = 0; b < BURST_BYTES; b++) begin
      if (idx_q == 4'(b)) begin
        wr_byte = wdata_q[8*b +: 8];
        wr_mask = mask_q[b];
      end
    end
  end

  // State and datapath registers; reset aborts any burst without an end pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      lat2_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      ck_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      lat2_q  <= lat2_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      ck_q    <= ck_d;
    end
  end

  // Next-state logic and pad/handshake outputs.
  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    cnt_d           = cnt_q;
    tmo_d           = tmo_q;
    lat2_d          = lat2_q;
    rdata_d         = rdata_q;
    err_d           = err_q;
    cs_bar          = 1'b1;
    dq_oe           = 1'b0;
    dq_out          = 8'h00;
    rwds_oe         = 1'b0;
    rwds_out        = 1'b0;
    transaction_end = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (transaction_begin) begin
          state_d = S_CA;
          idx_d   = '0;
          lat2_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_CA: begin
        cs_bar = 1'b0;
        dq_oe  = 1'b1;
        dq_out = ca_byte;
        // The device signals double latency on rwds during the third CA byte.
        if (idx_q == 4'd2) lat2_d = rwds_in | fixed_q;
        if (idx_q == 4'd5) begin
          idx_d   = '0;
          cnt_d   = '0;
          state_d = reg_wr ? S_WR : S_LAT;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      S_LAT: begin
        cs_bar = 1'b0;
        if (cnt_q == lat_tgt - 7'd1) begin
          cnt_d   = '0;
          tmo_d   = '0;
          state_d = we_q ? S_WR : S_RD0;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      S_WR: begin
        cs_bar = 1'b0;
        dq_oe  = 1'b1;
        if (reg_wr) begin
          // Register writes carry a single 16-bit word, high byte first, no mask.
          dq_out = (idx_q == 4'd0) ? wdata_q[15:8] : wdata_q[7:0];
        end else begin
          dq_out   = wr_byte;
          rwds_oe  = 1'b1;
          rwds_out = ~wr_mask;
        end
        if (reg_wr ? (idx_q == 4'd1) : (idx_q == LAST_IDX)) begin
          idx_d   = '0;
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      S_RD0: begin
        cs_bar = 1'b0;
        if (rwds_in || timed_q) begin
          rdata_d[7:0] = dq_in;
          idx_d        = 4'd1;
          state_d      = S_RD;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          tmo_d   = '0;
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_RD: begin
        cs_bar = 1'b0;
        for (int b = 1; b < BURST_BYTES; b++) begin
          if (idx_q == 4'(b)) rdata_d[8*b +: 8] = dq_in;
        end
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      S_DONE: begin
        if (cnt_q == done_len - 7'd1) begin
          transaction_end = 1'b1;
          cnt_d           = '0;
          state_d         = S_IDLE;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The device clock runs only while CS# is active.
    ck_d = (state_d inside {S_CA, S_LAT, S_WR, S_RD0, S_RD}) ? ~ck_q : 1'b0;
  end

endmodule

// File: tb/tb_hyperram_burst_ctrl.sv
module tb_hyperram_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [22:0] address;
  logic [31:0] data_out;
  logic [31:0] data_in;
  logic        write_enable;
  logic [3:0]  write_mask;
  logic        reg_space;
  logic        transaction_begin;
  logic        ready;
  logic        transaction_end;
  logic        error;
  logic [5:0]  wait_latency;
  logic [5:0]  done_latency;
  logic        fixed_latency;
  logic        timed_read;
  logic [7:0]  dq_out;
  logic        dq_oe;
  logic [7:0]  dq_in;
  logic        rwds_out;
  logic        rwds_oe;
  logic        rwds_in;
  logic        ck;
  logic        ck_bar;
  logic        cs_bar;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  hyperram_burst_ctrl #(
    .BURST_BYTES (4),
    .ADDR_WIDTH  (23),
    .READ_TIMEOUT(64)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .address          (address),
    .data_out         (data_out),
    .data_in          (data_in),
    .write_enable     (write_enable),
    .write_mask       (write_mask),
    .reg_space        (reg_space),
    .transaction_begin(transaction_begin),
    .ready            (ready),
    .transaction_end  (transaction_end),
    .error            (error),
    .wait_latency     (wait_latency),
    .done_latency     (done_latency),
    .fixed_latency    (fixed_latency),
    .timed_read       (timed_read),
    .dq_out           (dq_out),
    .dq_oe            (dq_oe),
    .dq_in            (dq_in),
    .rwds_out         (rwds_out),
    .rwds_oe          (rwds_oe),
    .rwds_in          (rwds_in),
    .ck               (ck),
    .ck_bar           (ck_bar),
    .cs_bar           (cs_bar)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge; returns in the first CA cycle.
  task automatic issue(input logic we, input logic rs, input logic [22:0] a,
                       input logic [31:0] d, input logic [3:0] m);
    write_enable      = we;
    reg_space         = rs;
    address           = a;
    data_out          = d;
    write_mask        = m;
    transaction_begin = 1'b1;
    step();
    transaction_begin = 1'b0;
  endtask

  // Steps until the end pulse; cyc counts cycles inclusive from the request cycle, -1 on timeout.
  task automatic wait_end(output int cyc);
    cyc = 2;
    while (transaction_end !== 1'b1 && cyc < 400) begin
      step();
      cyc++;
    end
    if (transaction_end !== 1'b1) cyc = -1;
  endtask

  task automatic test_reset();
    logic [17:0] got;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    // cs_bar, ck, ck_bar, dq_oe, rwds_oe, dq_out, rwds_out, error, end, ready
    got = {cs_bar, ck, ck_bar, dq_oe, rwds_oe, dq_out, rwds_out, error, transaction_end, ready};
    vec_cnt++;
    if (got !== {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      err_cnt++;
      $display("FAIL reset_pads: got %b expected %b", got,
               {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
    end
    vec_cnt++;
    if (data_in !== 32'h0) begin
      err_cnt++;
      $display("FAIL reset_data_in: got %h expected 00000000", data_in);
    end
    step();
    step();
    #3 rst_n = 1'b1;
    step();
    vec_cnt++;
    if (ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL reset_ready: got %b expected 1", ready);
    end
  endtask

  task automatic test_write();
    // CA[47]=0 write, [46]=0, [45]=1, [44:16]=0x123>>3=0x24, [2:0]=3
    logic [47:0] ca_w = 48'h2000_0024_0003;
    logic [31:0] dq_w = 32'hCCCC_DDDD;
    logic [3:0]  rw_w = 4'b1010;
    logic [12:0] got, exp;
    issue(1'b1, 1'b0, 23'h000123, 32'hCCCC_DDDD, 4'b0101);
    for (int i = 0; i < 6; i++) begin
      got = {cs_bar, dq_oe, rwds_oe, dq_out, ck, ck_bar};
      exp = {1'b0, 1'b1, 1'b0, ca_w[47-8*i -: 8], 1'(i % 2 == 0), 1'(i % 2 != 0)};
      vec_cnt++;
      if (got !== exp) begin
        err_cnt++;
        $display("FAIL write_ca%0d: got %b expected %b", i, got, exp);
      end
      step();
    end
    for (int i = 0; i < 4; i++) begin
      vec_cnt++;
      if ({cs_bar, dq_oe, rwds_oe} !== 3'b000) begin
        err_cnt++;
        $display("FAIL write_lat%0d: got %b expected 000", i, {cs_bar, dq_oe, rwds_oe});
      end
      step();
    end
    for (int i = 0; i < 4; i++) begin
      got = {1'b0, cs_bar, dq_oe, rwds_oe, rwds_out, dq_out};
      exp = {1'b0, 1'b0, 1'b1, 1'b1, rw_w[i], dq_w[8*i +: 8]};
      vec_cnt++;
      if (got !== exp) begin
        err_cnt++;
        $display("FAIL write_data%0d: got %b expected %b", i, got, exp);
      end
      step();
    end
    vec_cnt++;
    if ({cs_bar, ck, dq_oe, transaction_end, ready} !== 5'b10000) begin
      err_cnt++;
      $display("FAIL write_done0: got %b expected 10000", {cs_bar, ck, dq_oe, transaction_end, ready});
    end
    step();
    vec_cnt++;
    if ({cs_bar, transaction_end} !== 2'b11) begin
      err_cnt++;
      $display("FAIL write_end: got %b expected 11", {cs_bar, transaction_end});
    end
    step();
    vec_cnt++;
    if ({ready, transaction_end} !== 2'b10) begin
      err_cnt++;
      $display("FAIL write_idle: got %b expected 10", {ready, transaction_end});
    end
  endtask

  task automatic test_read();
    rwds_in = 1'b0;
    dq_in   = 8'h00;
    issue(1'b0, 1'b0, 23'h000040, 32'h0, 4'hF);
    vec_cnt++;
    if (dq_out !== 8'hA0) begin
      err_cnt++;
      $display("FAIL read_ca0: got %h expected a0", dq_out);
    end
    repeat (10) step();
    repeat (3) step();
    vec_cnt++;
    if ({cs_bar, dq_oe, data_in} !== {1'b0, 1'b0, 32'h0}) begin
      err_cnt++;
      $display("FAIL read_wait: got %b/%h expected 00/00000000", {cs_bar, dq_oe}, data_in);
    end
    rwds_in = 1'b1;
    dq_in   = 8'h11;
    step();
    rwds_in = 1'b0;
    vec_cnt++;
    if (data_in !== 32'h0000_0011) begin
      err_cnt++;
      $display("FAIL read_byte0: got %h expected 00000011", data_in);
    end
    dq_in = 8'h22;
    step();
    dq_in = 8'h33;
    step();
    dq_in = 8'h44;
    step();
    vec_cnt++;
    if ({cs_bar, error, data_in} !== {1'b1, 1'b0, 32'h4433_2211}) begin
      err_cnt++;
      $display("FAIL read_data: got %b/%b/%h expected 1/0/44332211", cs_bar, error, data_in);
    end
    step();
    vec_cnt++;
    if (transaction_end !== 1'b1) begin
      err_cnt++;
      $display("FAIL read_end: got %b expected 1", transaction_end);
    end
    step();
  endtask

  task automatic test_latency();
    // rwds at CA2, fixed, L, D, expected inclusive request-to-end cycles
    logic       c_rwds [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       c_fix  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [5:0] c_l    [5] = '{6'd4, 6'd4, 6'd4, 6'd0, 6'd3};
    logic [5:0] c_d    [5] = '{6'd2, 6'd2, 6'd2, 6'd0, 6'd3};
    int         c_exp  [5] = '{17, 21, 21, 13, 20};
    int cyc;
    timed_read = 1'b1;
    dq_in      = 8'h5A;
    for (int k = 0; k < 5; k++) begin
      rwds_in       = c_rwds[k];
      fixed_latency = c_fix[k];
      wait_latency  = c_l[k];
      done_latency  = c_d[k];
      issue(1'b0, 1'b0, 23'h000100, 32'h0, 4'hF);
      wait_end(cyc);
      vec_cnt++;
      if (cyc != c_exp[k]) begin
        err_cnt++;
        $display("FAIL latency_case%0d: got %0d cycles expected %0d", k, cyc, c_exp[k]);
      end
      step();
    end
    vec_cnt++;
    if (data_in !== 32'h5A5A_5A5A) begin
      err_cnt++;
      $display("FAIL timed_read_data: got %h expected 5a5a5a5a", data_in);
    end
    rwds_in       = 1'b0;
    fixed_latency = 1'b0;
    timed_read    = 1'b0;
    wait_latency  = 6'd4;
    done_latency  = 6'd2;
  endtask

  task automatic test_timeout();
    int cyc;
    dq_in = 8'h77;
    issue(1'b0, 1'b0, 23'h000200, 32'h0, 4'hF);
    wait_end(cyc);
    vec_cnt++;
    if (cyc != 77) begin
      err_cnt++;
      $display("FAIL timeout_cycles: got %0d expected 77", cyc);
    end
    vec_cnt++;
    if ({error, data_in} !== {1'b1, 32'h5A5A_5A5A}) begin
      err_cnt++;
      $display("FAIL timeout_flag: got %b/%h expected 1/5a5a5a5a", error, data_in);
    end
    step();
    vec_cnt++;
    if ({ready, error} !== 2'b11) begin
      err_cnt++;
      $display("FAIL timeout_idle: got %b expected 11", {ready, error});
    end
    issue(1'b1, 1'b0, 23'h000008, 32'h1234_5678, 4'hF);
    vec_cnt++;
    if (error !== 1'b0) begin
      err_cnt++;
      $display("FAIL error_clear: got %b expected 0", error);
    end
    wait_end(cyc);
    vec_cnt++;
    if (cyc != 17) begin
      err_cnt++;
      $display("FAIL after_timeout_write: got %0d expected 17", cyc);
    end
    step();
  endtask

  task automatic test_reg_write();
    issue(1'b1, 1'b1, 23'h000001, 32'h0000_8F1F, 4'hF);
    vec_cnt++;
    if (dq_out !== 8'h60) begin
      err_cnt++;
      $display("FAIL reg_ca0: got %h expected 60", dq_out);
    end
    repeat (6) step();
    vec_cnt++;
    if ({cs_bar, dq_oe, rwds_oe, dq_out} !== {3'b010, 8'h8F}) begin
      err_cnt++;
      $display("FAIL reg_byte0: got %b expected %b", {cs_bar, dq_oe, rwds_oe, dq_out}, {3'b010, 8'h8F});
    end
    step();
    vec_cnt++;
    if ({cs_bar, dq_oe, rwds_oe, dq_out} !== {3'b010, 8'h1F}) begin
      err_cnt++;
      $display("FAIL reg_byte1: got %b expected %b", {cs_bar, dq_oe, rwds_oe, dq_out}, {3'b010, 8'h1F});
    end
    step();
    vec_cnt++;
    if ({cs_bar, dq_oe, transaction_end} !== 3'b100) begin
      err_cnt++;
      $display("FAIL reg_done0: got %b expected 100", {cs_bar, dq_oe, transaction_end});
    end
    step();
    vec_cnt++;
    if (transaction_end !== 1'b1) begin
      err_cnt++;
      $display("FAIL reg_end: got %b expected 1", transaction_end);
    end
    step();
  endtask

  task automatic test_reset_midburst();
    logic saw_end = 1'b0;
    int   cyc;
    issue(1'b1, 1'b0, 23'h000010, 32'hCCCC_DDDD, 4'h0);
    repeat (11) step();
    vec_cnt++;
    if ({dq_oe, rwds_oe, dq_out} !== {2'b11, 8'hDD}) begin
      err_cnt++;
      $display("FAIL midburst_wr1: got %b expected %b", {dq_oe, rwds_oe, dq_out}, {2'b11, 8'hDD});
    end
    #2 rst_n = 1'b0;
    #1;
    vec_cnt++;
    if ({cs_bar, ck, ck_bar, dq_oe, rwds_oe, ready} !== 6'b101000) begin
      err_cnt++;
      $display("FAIL midburst_abort: got %b expected 101000", {cs_bar, ck, ck_bar, dq_oe, rwds_oe, ready});
    end
    for (int i = 0; i < 4; i++) begin
      if (transaction_end !== 1'b0) saw_end = 1'b1;
      step();
    end
    #3 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (transaction_end !== 1'b0) saw_end = 1'b1;
      step();
    end
    vec_cnt++;
    if (saw_end !== 1'b0) begin
      err_cnt++;
      $display("FAIL midburst_no_end: got %b expected 0", saw_end);
    end
    issue(1'b1, 1'b0, 23'h000010, 32'hCCCC_DDDD, 4'hF);
    wait_end(cyc);
    vec_cnt++;
    if (cyc != 17) begin
      err_cnt++;
      $display("FAIL midburst_recover: got %0d expected 17", cyc);
    end
    step();
  endtask

  initial begin
    rst_n             = 1'b1;
    address           = '0;
    data_out          = '0;
    write_enable      = 1'b0;
    write_mask        = '0;
    reg_space         = 1'b0;
    transaction_begin = 1'b0;
    wait_latency      = 6'd4;
    done_latency      = 6'd2;
    fixed_latency     = 1'b0;
    timed_read        = 1'b0;
    dq_in             = 8'h00;
    rwds_in           = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_latency();
    test_timeout();
    test_reg_write();
    test_reset_midburst();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
